// File: rtl/hmc_tx_collect_pkg.sv
// Shared types and constants for the HMC TX packet collector.
package hmc_tx_collect_pkg;

  localparam int unsigned FPW            = 4;
  localparam int unsigned FLIT_SIZE      = 128;
  localparam int unsigned DWIDTH         = FPW * FLIT_SIZE;
  localparam int unsigned MAX_LNG        = 9;
  localparam int unsigned PKT_FIFO_DEPTH = 8;

  localparam int unsigned LNG_MSB = 10;
  localparam int unsigned LNG_LSB = 7;
  localparam int unsigned LNG_W   = LNG_MSB - LNG_LSB + 1;

  typedef enum logic {
    ST_IDLE,
    ST_COLLECT
  } parse_state_t;

  typedef logic [FLIT_SIZE-1:0] flit_t;

  localparam flit_t NULL_FLIT = '0;

  typedef struct packed {
    flit_t [MAX_LNG-1:0] data;
    logic  [LNG_W-1:0]   lng;
  } pkt_entry_t;

  function automatic logic [LNG_W-1:0] hdr_lng(flit_t f);
    return f[LNG_MSB:LNG_LSB];
  endfunction

endpackage

// File: rtl/hmc_pkt_mpush_fifo.sv
// Packet FIFO accepting up to NPUSH pushes and one pop per cycle.
module hmc_pkt_mpush_fifo
  import hmc_tx_collect_pkg::*;
#(
  parameter int unsigned DEPTH = PKT_FIFO_DEPTH,
  parameter int unsigned NPUSH = FPW
) (
  input  logic                   clk,
  input  logic                   res_n,
  input  logic [NPUSH-1:0]       push,
  input  pkt_entry_t [NPUSH-1:0] push_data,
  input  logic                   pop,
  output pkt_entry_t             head,
  output logic                   head_valid,
  output logic [$clog2(DEPTH):0] free_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  pkt_entry_t       mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    acc;
  logic [NPUSH-1:0] wr_en;
  logic [AW-1:0]    wr_addr [NPUSH];
  logic             pop_ok;

  assign free_cnt   = CW'(DEPTH) - count_q;
  assign head_valid = (count_q != '0);
  assign head       = mem[rd_ptr_q];
  assign pop_ok     = pop && head_valid;

  // Valid pushes are packed into consecutive slots; those beyond free_cnt are dropped.
  always_comb begin
    acc   = '0;
    wr_en = '0;
    for (int i = 0; i < NPUSH; i++) begin
      wr_addr[i] = wr_ptr_q + acc[AW-1:0];
      if (push[i] && (acc < free_cnt)) begin
        wr_en[i] = 1'b1;
        acc      = acc + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NPUSH; i++) begin
      if (wr_en[i]) mem[wr_addr[i]] <= push_data[i];
    end
  end

  always_ff @(posedge clk) begin
    if (res_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + acc[AW-1:0];
      rd_ptr_q <= rd_ptr_q + AW'(pop_ok);
      count_q  <= count_q + acc - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/hmc_tx_pkt_collector.sv
// Collects HMC packets from raw TX beats into a packet FIFO.
// Optional statistics counters are enabled by defining HMC_TX_COLLECT_STATS_EN.
module hmc_tx_pkt_collector
  import hmc_tx_collect_pkg::*;
(
  input  logic                         clk,
  input  logic                         res_n,
  input  logic [DWIDTH-1:0]            phy_data_tx_link2phy,
  output logic [MAX_LNG*FLIT_SIZE-1:0] pkt_data,
  output logic [3:0]                   pkt_lng,
  output logic                         pkt_valid,
  input  logic                         pkt_ready,
  output logic                         overflow_err,
  output logic                         lng_err,
  output logic [31:0]                  pkt_count,
  output logic [31:0]                  null_count
);

  localparam int unsigned CW = $clog2(PKT_FIFO_DEPTH) + 1;
  localparam int unsigned OW = $clog2(MAX_LNG);

  logic [DWIDTH-1:0]   beat_q;
  logic                beat_vld_q;
  parse_state_t        state_q, state_d;
  logic [OW-1:0]       off_q, off_d;
  logic [LNG_W-1:0]    rem_q, rem_d;
  logic [LNG_W-1:0]    lng_q, lng_d;
  flit_t [MAX_LNG-1:0] pbuf_q, pbuf_d;
  logic [FPW-1:0]      comp_vld;
  pkt_entry_t [FPW-1:0] comp_ent;
  logic [CW-1:0]       num_comp;
  logic [CW-1:0]       free_cnt;
  logic                lng_hit;
  flit_t               flit;
  logic [LNG_W-1:0]    hlng;
  pkt_entry_t          head;
  logic                ovf_q;
  logic                lerr_q;
`ifdef HMC_TX_COLLECT_STATS_EN
  localparam int unsigned NW = $clog2(FPW + 1);
  logic [NW-1:0]       nulls;
`endif

  // The beat is registered first; parsing and FIFO push happen in the following cycle.
  always_ff @(posedge clk) begin
    if (res_n) begin
      beat_q     <= '0;
      beat_vld_q <= 1'b0;
      state_q    <= ST_IDLE;
      off_q      <= '0;
      rem_q      <= '0;
      lng_q      <= '0;
      pbuf_q     <= '0;
      ovf_q      <= 1'b0;
      lerr_q     <= 1'b0;
    end else begin
      beat_q     <= phy_data_tx_link2phy;
      beat_vld_q <= 1'b1;
      state_q    <= state_d;
      off_q      <= off_d;
      rem_q      <= rem_d;
      lng_q      <= lng_d;
      pbuf_q     <= pbuf_d;
      ovf_q      <= ovf_q | (num_comp > free_cnt);
      lerr_q     <= lerr_q | lng_hit;
    end
  end

  // Walk the flits of the beat in order, carrying parser state from flit to flit.
  always_comb begin
    state_d  = state_q;
    off_d    = off_q;
    rem_d    = rem_q;
    lng_d    = lng_q;
    pbuf_d   = pbuf_q;
    comp_vld = '0;
    comp_ent = '0;
    lng_hit  = 1'b0;
    flit     = NULL_FLIT;
    hlng     = '0;
`ifdef HMC_TX_COLLECT_STATS_EN
    nulls    = '0;
`endif
    if (beat_vld_q) begin
      for (int i = 0; i < FPW; i++) begin
        flit = beat_q[i*FLIT_SIZE +: FLIT_SIZE];
        if (state_d == ST_IDLE) begin
          if (flit == NULL_FLIT) begin
`ifdef HMC_TX_COLLECT_STATS_EN
            nulls = nulls + NW'(1);
`endif
          end else begin
            hlng = hdr_lng(flit);
            if ((hlng == '0) || (hlng > LNG_W'(MAX_LNG))) begin
              lng_hit = 1'b1;
            end else begin
              pbuf_d    = '0;
              pbuf_d[0] = flit;
              off_d     = OW'(1);
              rem_d     = hlng - LNG_W'(1);
              lng_d     = hlng;
              if (rem_d == '0) begin
                comp_vld[i] = 1'b1;
                comp_ent[i] = '{data: pbuf_d, lng: lng_d};
              end else begin
                state_d = ST_COLLECT;
              end
            end
          end
        end else begin
          pbuf_d[off_d] = flit;
          off_d         = off_d + OW'(1);
          rem_d         = rem_d - LNG_W'(1);
          if (rem_d == '0) begin
            comp_vld[i] = 1'b1;
            comp_ent[i] = '{data: pbuf_d, lng: lng_d};
            state_d     = ST_IDLE;
          end
        end
      end
    end
    num_comp = CW'($countones(comp_vld));
  end

  hmc_pkt_mpush_fifo #(
    .DEPTH (PKT_FIFO_DEPTH),
    .NPUSH (FPW)
  ) u_fifo (
    .clk        (clk),
    .res_n      (res_n),
    .push       (comp_vld),
    .push_data  (comp_ent),
    .pop        (pkt_valid && pkt_ready),
    .head       (head),
    .head_valid (pkt_valid),
    .free_cnt   (free_cnt)
  );

  assign pkt_data     = pkt_valid ? head.data : '0;
  assign pkt_lng      = pkt_valid ? head.lng  : '0;
  assign overflow_err = ovf_q;
  assign lng_err      = lerr_q;

`ifdef HMC_TX_COLLECT_STATS_EN
  logic [31:0] pkt_cnt_q;
  logic [31:0] null_cnt_q;
  logic [CW-1:0] pushed;

  assign pushed = (num_comp > free_cnt) ? free_cnt : num_comp;

  always_ff @(posedge clk) begin
    if (res_n) begin
      pkt_cnt_q  <= '0;
      null_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_q + 32'(pushed);
      null_cnt_q <= null_cnt_q + 32'(nulls);
    end
  end

  assign pkt_count  = pkt_cnt_q;
  assign null_count = null_cnt_q;
`else
  assign pkt_count  = '0;
  assign null_count = '0;
`endif

endmodule

// File: tb/tb_hmc_tx_pkt_collector.sv
// Self-checking bench: directed vector table, corner sequences and random traffic vs a queue model.
module tb_hmc_tx_pkt_collector;
  import hmc_tx_collect_pkg::*;

  localparam int unsigned PW = MAX_LNG * FLIT_SIZE;
`ifdef HMC_TX_COLLECT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              res_n;
  logic [DWIDTH-1:0] phy;
  logic              pkt_ready;
  logic [PW-1:0]     pkt_data;
  logic [3:0]        pkt_lng;
  logic              pkt_valid;
  logic              overflow_err;
  logic              lng_err;
  logic [31:0]       pkt_count;
  logic [31:0]       null_count;

  always #5 clk = ~clk;

  hmc_tx_pkt_collector dut (
    .clk                  (clk),
    .res_n                (res_n),
    .phy_data_tx_link2phy (phy),
    .pkt_data             (pkt_data),
    .pkt_lng              (pkt_lng),
    .pkt_valid            (pkt_valid),
    .pkt_ready            (pkt_ready),
    .overflow_err         (overflow_err),
    .lng_err              (lng_err),
    .pkt_count            (pkt_count),
    .null_count           (null_count)
  );

  int checks = 0;
  int passed = 0;

  // Reference model: packets as flit queues, FIFO as a queue of packets.
  typedef struct {
    logic [PW-1:0] data;
    int            lng;
  } pkt_t;

  pkt_t        m_fifo[$];
  pkt_t        m_pend[$];
  flit_t       m_cur[$];
  int          m_need;
  bit          m_in;
  int          m_pnull;
  bit          m_plerr;
  bit          m_ovf;
  bit          m_lerr;
  logic [31:0] m_pkts;
  logic [31:0] m_nulls;

  function automatic flit_t hdr(int lng, int tag);
    return (flit_t'(lng) << 7) | (flit_t'(tag) << 16);
  endfunction

  function automatic logic [DWIDTH-1:0] mk(flit_t f0, flit_t f1, flit_t f2, flit_t f3);
    return {f3, f2, f1, f0};
  endfunction

  function automatic flit_t rnd_flit();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void m_emit();
    pkt_t p;
    p.data = '0;
    foreach (m_cur[k]) p.data[k*FLIT_SIZE +: FLIT_SIZE] = m_cur[k];
    p.lng = m_cur.size();
    m_pend.push_back(p);
  endfunction

  function automatic void m_parse(flit_t f);
    int l;
    if (!m_in) begin
      if (f == '0) m_pnull++;
      else begin
        l = int'(f[10:7]);
        if (l < 1 || l > int'(MAX_LNG)) m_plerr = 1'b1;
        else begin
          m_cur.delete();
          m_cur.push_back(f);
          m_need = l - 1;
          if (m_need == 0) m_emit();
          else m_in = 1'b1;
        end
      end
    end else begin
      m_cur.push_back(f);
      m_need--;
      if (m_need == 0) begin
        m_emit();
        m_in = 1'b0;
      end
    end
  endfunction

  function automatic void m_edge(bit rst, logic [DWIDTH-1:0] b, bit rdy);
    int free;
    if (rst) begin
      m_fifo.delete(); m_pend.delete(); m_cur.delete();
      m_in = 1'b0; m_need = 0; m_pnull = 0; m_plerr = 1'b0;
      m_ovf = 1'b0; m_lerr = 1'b0; m_pkts = '0; m_nulls = '0;
      return;
    end
    free = int'(PKT_FIFO_DEPTH) - m_fifo.size();
    if (rdy && m_fifo.size() > 0) void'(m_fifo.pop_front());
    foreach (m_pend[k]) begin
      if (k < free) begin
        m_fifo.push_back(m_pend[k]);
        m_pkts++;
      end else m_ovf = 1'b1;
    end
    m_nulls += 32'(m_pnull);
    if (m_plerr) m_lerr = 1'b1;
    m_pend.delete();
    m_pnull = 0;
    m_plerr = 1'b0;
    for (int i = 0; i < int'(FPW); i++) m_parse(b[i*FLIT_SIZE +: FLIT_SIZE]);
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic chk_data(string nm, logic [PW-1:0] act, logic [PW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else begin
      int k;
      k = 0;
      for (int j = int'(MAX_LNG) - 1; j >= 0; j--)
        if (act[j*FLIT_SIZE +: FLIT_SIZE] !== exp[j*FLIT_SIZE +: FLIT_SIZE]) k = j;
      $display("FAIL %s flit %0d: got %h want %h", nm, k,
               act[k*FLIT_SIZE +: FLIT_SIZE], exp[k*FLIT_SIZE +: FLIT_SIZE]);
    end
  endtask

  task automatic check_model();
    pkt_t h;
    chk("pkt_valid", 64'(pkt_valid), 64'(m_fifo.size() > 0));
    if (m_fifo.size() > 0) begin
      h = m_fifo[0];
      chk("pkt_lng", 64'(pkt_lng), 64'(h.lng));
      chk_data("pkt_data", pkt_data, h.data);
    end
    chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
    chk("lng_err", 64'(lng_err), 64'(m_lerr));
    chk("pkt_count", 64'(pkt_count), STATS ? 64'(m_pkts) : 64'd0);
    chk("null_count", 64'(null_count), STATS ? 64'(m_nulls) : 64'd0);
  endtask

  task automatic step(bit rst, logic [DWIDTH-1:0] b, bit rdy);
    res_n     = rst;
    phy       = b;
    pkt_ready = rdy;
    @(posedge clk);
    m_edge(rst, b, rdy);
    @(negedge clk);
    check_model();
    if (rst) begin
      chk("rst_lng", 64'(pkt_lng), 64'd0);
      chk_data("rst_data", pkt_data, '0);
    end
  endtask

  typedef struct {
    bit                rst;
    bit                rdy;
    logic [DWIDTH-1:0] beat;
    bit                e_valid;
    logic [3:0]        e_lng;
    logic [PW-1:0]     e_data;
    bit                e_lerr;
    bit                e_ovf;
  } vec_t;

  function automatic vec_t mv(bit rst, bit rdy, logic [DWIDTH-1:0] beat, bit ev,
                              logic [3:0] el, logic [PW-1:0] ed, bit elerr);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.beat = beat; v.e_valid = ev;
    v.e_lng = el; v.e_data = ed; v.e_lerr = elerr; v.e_ovf = 1'b0;
    return v;
  endfunction

  vec_t tbl[10];

  initial begin
    logic [PW-1:0] d37;
    logic [PW-1:0] d40;
    int            drained;
    flit_t         f [4];

    res_n = 1'b1; phy = '0; pkt_ready = 1'b0;

    d37 = '0;
    d37[127:0]   = hdr(2, 0);
    d37[255:128] = flit_t'(8'hA5);
    d40 = '0;
    d40[127:0]   = hdr(1, 3);

    tbl[0] = mv(1, 1, '0, 0, 0, '0, 0);
    tbl[1] = mv(0, 1, '0, 0, 0, '0, 0);
    tbl[2] = mv(0, 1, mk(hdr(2, 0), flit_t'(8'hA5), '0, '0), 0, 0, '0, 0);
    tbl[3] = mv(0, 1, '0, 1, 2, d37, 0);
    tbl[4] = mv(0, 1, '0, 0, 0, '0, 0);
    tbl[5] = mv(0, 1, mk(flit_t'(1), hdr(12, 0), '0, '0), 0, 0, '0, 0);
    tbl[6] = mv(0, 0, mk(hdr(1, 3), '0, '0, '0), 0, 0, '0, 1);
    tbl[7] = mv(0, 0, '0, 1, 1, d40, 1);
    tbl[8] = mv(0, 0, '0, 1, 1, d40, 1);
    tbl[9] = mv(0, 1, '0, 0, 0, '0, 1);

    @(negedge clk);
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].beat, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), 64'(pkt_valid), 64'(tbl[i].e_valid));
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d_lng", i), 64'(pkt_lng), 64'(tbl[i].e_lng));
        chk_data($sformatf("tbl%0d_data", i), pkt_data, tbl[i].e_data);
      end
      chk($sformatf("tbl%0d_lng_err", i), 64'(lng_err), 64'(tbl[i].e_lerr));
      chk($sformatf("tbl%0d_ovf", i), 64'(overflow_err), 64'(tbl[i].e_ovf));
    end

    // Overflow: 12 single-flit packets with the consumer stalled.
    step(1, '0, 0);
    for (int b = 0; b < 3; b++)
      step(0, mk(hdr(1, 4*b), hdr(1, 4*b+1), hdr(1, 4*b+2), hdr(1, 4*b+3)), 0);
    step(0, '0, 0);
    step(0, '0, 0);
    chk("ovf_set", 64'(overflow_err), 64'd1);
    drained = 0;
    for (int c = 0; c < 12; c++) begin
      if (pkt_valid) drained++;
      step(0, '0, 1);
    end
    chk("ovf_drained", 64'(drained), 64'd8);
    chk("ovf_sticky", 64'(overflow_err), 64'd1);

    // Max-length packet whose header is the last flit of a beat.
    step(1, '0, 1);
    step(0, mk(hdr(1, 20), hdr(1, 21), hdr(1, 22), hdr(4, 23)), 1);
    step(0, mk(rnd_flit(), rnd_flit(), rnd_flit(), hdr(9, 24)), 1);
    step(0, mk(rnd_flit(), '0, rnd_flit(), rnd_flit()), 1);
    step(0, mk(rnd_flit(), rnd_flit(), rnd_flit(), '0), 1);
    step(0, mk(hdr(1, 25), hdr(1, 26), hdr(1, 27), hdr(1, 28)), 1);
    chk("lng9_nulls", 64'(null_count), 64'd0);
    for (int c = 0; c < 8; c++) step(0, '0, 1);

    // Reset in the middle of an LNG=5 packet.
    step(1, '0, 1);
    step(0, mk('0, hdr(5, 30), rnd_flit(), rnd_flit()), 1);
    step(1, mk(hdr(1, 31), '0, '0, '0), 1);
    chk("mid_rst_valid", 64'(pkt_valid), 64'd0);
    chk("mid_rst_flags", 64'({overflow_err, lng_err}), 64'd0);
    step(0, mk(hdr(3, 32), rnd_flit(), rnd_flit(), '0), 0);
    for (int c = 0; c < 4; c++) step(0, '0, 0);
    chk("post_rst_lng", 64'(pkt_lng), 64'd3);
    step(0, '0, 1);

    // Null-only beats.
    step(1, '0, 1);
    for (int c = 0; c < 5; c++) step(0, '0, 1);
    chk("null_only_cnt", 64'(null_count), STATS ? 64'd16 : 64'd0);
    chk("null_only_valid", 64'(pkt_valid), 64'd0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        int r;
        r = int'($urandom_range(0, 9));
        f[i] = rnd_flit();
        if (r <= 2) f[i] = '0;
        else if (r <= 7) f[i][10:7] = 4'($urandom_range(1, 9));
        else if (r == 9) f[i][10:7] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(10, 15));
      end
      step($urandom_range(0, 299) == 0, mk(f[0], f[1], f[2], f[3]), $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/hmc_tx_pkt_collector.md
HMC_TX_PKT_COLLECTOR -- requirements
Module: hmc_tx_pkt_collector

Interface
REQ-001 DWIDTH, 512, TX beat width in bits; SHALL equal FPW*FLIT_SIZE.
REQ-002 FPW, 4, flits per beat.
REQ-003 FLIT_SIZE, 128, flit width in bits.
REQ-004 MAX_LNG, 9, maximum packet length in flits.
REQ-005 PKT_FIFO_DEPTH, 8, packet FIFO entries; SHALL be a power of 2 and at least FPW.
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 res_n  in  1  reset, synchronous, active-high (1 = reset).
REQ-008 phy_data_tx_link2phy  in  DWIDTH  TX beat; one beat is sampled every cycle, with no valid qualifier.
REQ-009 pkt_data  out  MAX_LNG*FLIT_SIZE  packet; flit k sits at bits [k*FLIT_SIZE +: FLIT_SIZE]; unused flits are 0.
REQ-010 pkt_lng  out  4  length of the presented packet in flits.
REQ-011 pkt_valid  out  1  FIFO head valid.
REQ-012 pkt_ready  in  1  consumer accept.
REQ-013 overflow_err  out  1  sticky; set when a completed packet is dropped.
REQ-014 lng_err  out  1  sticky; set on an illegal header LNG.

Function
REQ-015 Flit i of a beat (bits [i*FLIT_SIZE +: FLIT_SIZE]) SHALL be processed before flit i+1 in the same cycle.
REQ-016 Parser states: IDLE (expecting header) and COLLECT (remaining > 0); state, write offset and remaining count carry across beats.
REQ-017 IDLE handling of a flit:
- all-zero flit is a null flit and SHALL be skipped;
- otherwise the flit is a header, with LNG = flit bits [10:7].
REQ-018 Legal header, 1 <= LNG <= MAX_LNG: store the flit at offset 0 and set remaining = LNG-1; if LNG = 1 the packet completes immediately.
REQ-019 Illegal header, LNG = 0 or LNG > MAX_LNG: set lng_err, discard the flit, stay in IDLE.
REQ-020 COLLECT: every flit, including an all-zero flit, SHALL be stored at the next offset; remaining decrements; completion occurs when remaining reaches 0.
REQ-021 A packet may span any number of beats, and up to FPW packets may complete in one beat.
REQ-022 Completed packets SHALL be pushed into the FIFO in flit order in the cycle after the beat is sampled (push latency 1).
REQ-023 When completions in a beat exceed free entries:
- the first N packets are pushed, where N = free entries;
- the remainder are dropped;
- overflow_err is set.
REQ-024 Free entries SHALL be computed before the same-cycle pop.
REQ-025 A pop occurs when pkt_valid && pkt_ready; a pop and pushes in the same cycle are both honoured.
REQ-026 pkt_data and pkt_lng SHALL hold stable while pkt_valid=1 and pkt_ready=0.
REQ-027 FIFO pointers wrap modulo PKT_FIFO_DEPTH; full and empty are distinguished by a count register.
REQ-028 Minimum header-to-pkt_valid latency is 2 cycles (sample, push).

Reset
REQ-029 With res_n=1, at the next edge:
- parser returns to IDLE;
- remaining = 0;
- FIFO is emptied;
- pkt_valid, overflow_err, lng_err, pkt_lng and pkt_data are 0.
REQ-030 A packet in progress when reset is asserted SHALL be discarded; the beat sampled in the reset cycle is ignored.
REQ-031 Sticky error flags SHALL clear only on reset.

Configuration
REQ-032 Macro HMC_TX_COLLECT_STATS_EN.
REQ-033 When defined, the block SHALL add these outputs:
- pkt_count (32 bits): increments by the number of pushed packets;
- null_count (32 bits): increments by the number of skipped null flits;
- both wrap at 2^32 and clear on reset.
REQ-034 When undefined, the ports SHALL exist and be tied to 0; no counter logic is present.

Structure
REQ-035 Package hmc_tx_collect_pkg SHALL hold:
- the parser state enum;
- the LNG field bit positions (10:7);
- the null flit constant;
- typedef flit_t (logic [FLIT_SIZE-1:0]);
- the packet entry struct (data, lng).
REQ-036 One sub-module, hmc_pkt_mpush_fifo: FIFO with up to FPW pushes and 1 pop per cycle, exposing free_cnt.

Verification
REQ-037 One beat: flit0 = header LNG=2, flit1 = data 0xA5, flits 2-3 = 0; pkt_ready=1 → exactly one packet, pkt_lng=2, pkt_valid rises 2 cycles after the beat, pkt_data[255:128] = 0xA5, no errors.
REQ-038 LNG=9 header in flit 3 of beat 0, with 8 data flits across beats 1-2 → one packet, pkt_lng=9, flits in order, null_count = 0 (STATS on).
REQ-039 Hold pkt_ready=0 and send 3 beats of four LNG=1 packets each (12 packets) → FIFO full at 8, 4 dropped, overflow_err=1; drain shows the first 8 packets in order.
REQ-040 Header with LNG=0, then header with LNG=12 → lng_err=1, no packets pushed, parser still IDLE; next LNG=1 header is accepted normally.
REQ-041 Assert res_n after the header and 2 of 5 flits of an LNG=5 packet → after reset pkt_valid=0 and all flags 0; next LNG=3 packet is received intact.
REQ-042 Beats of all-zero flits only → no packets; null_count increments by 4 per beat with STATS on, and reads 0 with STATS off.
